bf16_div: RTL and testbench

BF16_DIV -- requirements
Module: bf16_div

---
 rtl/bf16_pkg.sv | 30 +++
 rtl/bf16_div_round.sv | 72 +++++++
 rtl/bf16_div.sv | 172 +++++++++++++++++
 tb/tb_bf16_div.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/bf16_pkg.sv
// ============================================================================
// Module      : bf16_pkg
// Description : Shared bfloat16 constants, field widths and divider FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bf16_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 7;

    localparam logic [9:0]  BF16_BIAS    = 10'd127;
    localparam logic [15:0] BF16_QNAN    = 16'h7FC0;
    localparam logic [7:0]  BF16_INF_EXP = 8'hFF;

    // Quotient bits produced by the restoring divider, and the last step index
    localparam int         DIV_STEPS = 11;
    localparam logic [3:0] DIV_LAST  = 4'd10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } div_state_t;

endpackage

`default_nettype wire

// File: rtl/bf16_div_round.sv
// ============================================================================
// Module      : bf16_div_round
// Description : Combinational normalise, round and pack of the raw quotient.
//               Optional saturation/flush under BF16_DIV_SPECIAL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bf16_div_round
    import bf16_pkg::*;
#(
    parameter int ROUND_RNE = 1
) (
    input  logic [10:0]       q,
    input  logic [8:0]        rem,
    input  logic signed [9:0] exponent,
    input  logic              sign,
    output logic [15:0]       result
);

    logic [7:0]        w_mant;
    logic              w_guard;
    logic              w_round;
    logic              w_sticky;
    logic              w_inc;
    logic [8:0]        w_sum;
    logic [6:0]        w_frac;
    logic signed [9:0] w_exp_norm;
    logic signed [9:0] w_exp_fin;

    // Quotient lies in (0.5, 2); q[10] tells which binade it landed in
    always_comb begin
        if (q[10]) begin
            w_mant     = q[10:3];
            w_guard    = q[2];
            w_round    = q[1];
            w_sticky   = q[0] | (rem != 9'd0);
            w_exp_norm = exponent;
        end else begin
            w_mant     = q[9:2];
            w_guard    = q[1];
            w_round    = q[0];
            w_sticky   = (rem != 9'd0);
            w_exp_norm = exponent - 10'sd1;
        end
    end

    assign w_inc     = (ROUND_RNE != 0) && w_guard && (w_round || w_sticky || w_mant[0]);
    assign w_sum     = {1'b0, w_mant} + {8'd0, w_inc};
    assign w_frac    = w_sum[8] ? w_sum[7:1] : w_sum[6:0];
    assign w_exp_fin = w_sum[8] ? (w_exp_norm + 10'sd1) : w_exp_norm;

`ifdef BF16_DIV_SPECIAL_EN
    always_comb begin
        if (w_exp_fin >= 10'sd255) begin
            result = {sign, BF16_INF_EXP, {FRAC_W{1'b0}}};
        end else if (w_exp_fin <= 10'sd0) begin
            result = {sign, {(EXP_W + FRAC_W){1'b0}}};
        end else begin
            result = {sign, w_exp_fin[7:0], w_frac};
        end
    end
`else
    // Exponent simply wraps into its 8-bit field
    logic w_unused_exp_hi;
    assign w_unused_exp_hi = ^w_exp_fin[9:8];
    assign result          = {sign, w_exp_fin[7:0], w_frac};
`endif

endmodule

`default_nettype wire

// File: rtl/bf16_div.sv
// ============================================================================
// Module      : bf16_div
// Description : Multi-cycle bfloat16 divider (restoring, 11 quotient bits).
//               Define BF16_DIV_SPECIAL_EN for NaN/Inf/zero handling.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bf16_div
    import bf16_pkg::*;
#(
    parameter int ROUND_RNE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic        div_by_zero
);

    div_state_t        r_state;
    div_state_t        w_state_next;
    logic              r_sign;
    logic signed [9:0] r_exp;
    logic [7:0]        r_mb;
    logic [8:0]        r_rem;
    logic [10:0]       r_q;
    logic [3:0]        r_cnt;
    logic [15:0]       r_result;

    logic              w_accept;
    logic              w_bypass;
    logic signed [9:0] w_exp_cap;
    logic              w_ge;
    logic [8:0]        w_diff;
    logic [8:0]        w_rem_sel;
    logic [15:0]       w_round_result;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign result    = r_result;
    assign w_accept  = in_valid && in_ready;

    assign w_exp_cap = {2'b00, a[14:7]} - {2'b00, b[14:7]} + BF16_BIAS;

    assign w_ge      = (r_rem >= {1'b0, r_mb});
    assign w_diff    = r_rem - {1'b0, r_mb};
    assign w_rem_sel = w_ge ? w_diff : r_rem;

`ifdef BF16_DIV_SPECIAL_EN
    logic        r_dbz;
    logic        w_sign_cap;
    logic        w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic [15:0] w_special_result;
    logic        w_special_dbz;

    assign w_sign_cap = a[15] ^ b[15];
    assign w_a_zero   = (a[14:7] == 8'h00);
    assign w_b_zero   = (b[14:7] == 8'h00);
    assign w_a_inf    = (a[14:7] == BF16_INF_EXP) && (a[6:0] == 7'd0);
    assign w_b_inf    = (b[14:7] == BF16_INF_EXP) && (b[6:0] == 7'd0);
    assign w_a_nan    = (a[14:7] == BF16_INF_EXP) && (a[6:0] != 7'd0);
    assign w_b_nan    = (b[14:7] == BF16_INF_EXP) && (b[6:0] != 7'd0);

    // Priority matters: NaN first, then the x/0 cases so div_by_zero is set
    always_comb begin
        w_bypass         = 1'b1;
        w_special_dbz    = 1'b0;
        w_special_result = BF16_QNAN;
        if (w_a_nan || w_b_nan) begin
            w_special_result = BF16_QNAN;
        end else if (w_a_zero && w_b_zero) begin
            w_special_result = BF16_QNAN;
            w_special_dbz    = 1'b1;
        end else if (w_b_zero) begin
            w_special_result = {w_sign_cap, BF16_INF_EXP, 7'd0};
            w_special_dbz    = 1'b1;
        end else if (w_a_inf && w_b_inf) begin
            w_special_result = BF16_QNAN;
        end else if (w_a_inf) begin
            w_special_result = {w_sign_cap, BF16_INF_EXP, 7'd0};
        end else if (w_a_zero || w_b_inf) begin
            w_special_result = {w_sign_cap, 15'd0};
        end else begin
            w_bypass = 1'b0;
        end
    end

    assign div_by_zero = r_dbz;
`else
    assign w_bypass    = 1'b0;
    assign div_by_zero = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = w_bypass ? DONE : CALC;
            CALC:    if (r_cnt == DIV_LAST) w_state_next = ROUND;
            ROUND:   w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign   <= 1'b0;
            r_exp    <= '0;
            r_mb     <= '0;
            r_rem    <= '0;
            r_q      <= '0;
            r_cnt    <= '0;
            r_result <= '0;
`ifdef BF16_DIV_SPECIAL_EN
            r_dbz    <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_sign <= a[15] ^ b[15];
                        r_exp  <= w_exp_cap;
                        r_mb   <= {1'b1, b[FRAC_W-1:0]};
                        r_rem  <= {2'b01, a[FRAC_W-1:0]};
                        r_q    <= '0;
                        r_cnt  <= '0;
`ifdef BF16_DIV_SPECIAL_EN
                        r_result <= w_special_result;
                        r_dbz    <= w_special_dbz;
`endif
                    end
                end
                CALC: begin
                    r_q   <= {r_q[9:0], w_ge};
                    r_rem <= w_rem_sel << 1;
                    r_cnt <= r_cnt + 4'd1;
                end
                ROUND: begin
                    r_result <= w_round_result;
                end
                default: ;
            endcase
        end
    end

    bf16_div_round #(
        .ROUND_RNE (ROUND_RNE)
    ) u_round (
        .q        (r_q),
        .rem      (r_rem),
        .exponent (r_exp),
        .sign     (r_sign),
        .result   (w_round_result)
    );

endmodule

`default_nettype wire

// File: tb/tb_bf16_div.sv
// ============================================================================
// Module      : tb_bf16_div
// Description : Directed self-checking bench for bf16_div (RNE and truncate
//               instances side by side). Honours BF16_DIV_SPECIAL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bf16_div;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_ready;

    logic        in_ready, out_valid, div_by_zero;
    logic [15:0] result;
    logic        t_in_ready, t_out_valid, t_div_by_zero;
    logic [15:0] t_result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bf16_div #(.ROUND_RNE(1)) dut_rne (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    bf16_div #(.ROUND_RNE(0)) dut_trn (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (t_in_ready),
        .a           (a),
        .b           (b),
        .out_valid   (t_out_valid),
        .out_ready   (out_ready),
        .result      (t_result),
        .div_by_zero (t_div_by_zero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Issue one operand pair; lat counts edges with the accepting edge as edge 1
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, output int lat);
        a        = ta;
        b        = tb_v;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic finish_op(input string tag);
        @(posedge clk); #1;
        check({tag, " out_valid drop"}, {31'd0, out_valid}, 32'd0);
        check({tag, " in_ready back"},  {31'd0, in_ready},  32'd1);
    endtask

    initial begin
        int lat;
        logic seen;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst in_ready",    {31'd0, in_ready},    32'd1);
        check("rst out_valid",   {31'd0, out_valid},   32'd0);
        check("rst result",      {16'd0, result},      32'h0000);
        check("rst div_by_zero", {31'd0, div_by_zero}, 32'd0);
        rst_n = 1'b1;

        // 266 / 17, issued on the first edge after reset release
        run_op(16'h4385, 16'h4188, lat);
        check("266/17 latency", lat, 32'd13);
        check("266/17 rne",     {16'd0, result},   32'h417A);
        check("266/17 trn",     {16'd0, t_result}, 32'h417A);
        check("266/17 dbz",     {31'd0, div_by_zero}, 32'd0);
        finish_op("266/17");

        // -17 / -17
        run_op(16'hC188, 16'hC188, lat);
        check("-17/-17 latency", lat, 32'd13);
        check("-17/-17 rne", {16'd0, result},   32'h3F80);
        check("-17/-17 trn", {16'd0, t_result}, 32'h3F80);
        finish_op("-17/-17");

        // 1 / 3: rounding mode makes a visible difference
        run_op(16'h3F80, 16'h4040, lat);
        check("1/3 rne", {16'd0, result},   32'h3EAB);
        check("1/3 trn", {16'd0, t_result}, 32'h3EAA);
        finish_op("1/3");

        // Back-pressure in DONE with competing in_valid that must be ignored
        out_ready = 1'b0;
        run_op(16'h4385, 16'h4188, lat);
        check("hold latency", lat, 32'd13);
        a        = 16'h3F80;
        b        = 16'h4040;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold result",    {16'd0, result},    32'h417A);
            check("hold out_valid", {31'd0, out_valid}, 32'd1);
            check("hold in_ready",  {31'd0, in_ready},  32'd0);
        end
        out_ready = 1'b1;
        finish_op("hold release");
        in_valid = 1'b0;
        @(posedge clk); #1;

`ifdef BF16_DIV_SPECIAL_EN
        run_op(16'h4188, 16'h0000, lat);
        check("x/0 latency", lat, 32'd1);
        check("x/0 result",  {16'd0, result}, 32'h7F80);
        check("x/0 dbz",     {31'd0, div_by_zero}, 32'd1);
        finish_op("x/0");
        run_op(16'h0000, 16'h0000, lat);
        check("0/0 result",  {16'd0, result}, 32'h7FC0);
        check("0/0 dbz",     {31'd0, div_by_zero}, 32'd1);
        finish_op("0/0");
`else
        // Zero divisor treated as 1.0 * 2^-127: 17 * 2^127 wraps the exponent
        run_op(16'h4188, 16'h0000, lat);
        check("x/0 latency", lat, 32'd13);
        check("x/0 result",  {16'd0, result}, 32'h0108);
        check("x/0 dbz",     {31'd0, div_by_zero}, 32'd0);
        finish_op("x/0");
`endif

        // Reset during the 6th CALC cycle aborts the operation
        a        = 16'h4385;
        b        = 16'h4188;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("abort busy", {31'd0, in_ready}, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort in_ready",  {31'd0, in_ready},  32'd1);
        check("abort out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (16) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("abort no pulse", {31'd0, seen}, 32'd0);

        run_op(16'hC188, 16'hC188, lat);
        check("post-abort latency", lat, 32'd13);
        check("post-abort result",  {16'd0, result}, 32'h3F80);
        finish_op("post-abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
